// File: rtl/sha256_single_block.sv
// sha256_single_block: single-block SHA-256 with internal padding, one compression round per clock
module sha256_single_block (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [439:0] inputMsg,
  input  logic [63:0]  inputLength,
  input  logic         beginComputation,
  output logic         computationComplete,
  output logic [255:0] SHAoutput
);
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  state_t       state;
  logic [439:0] msg_r;
  logic [8:0]   len_r;
  logic [31:0]  w [16];
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [5:0]   t;
  logic [8:0]   len_sat;
  logic [439:0] msg_mask;
  logic [511:0] blk;
  logic [31:0]  t1, t2, w_new;
  // message is masked and saturated at acceptance so later input changes are irrelevant
  always_comb begin
    len_sat  = (inputLength > 64'd440) ? 9'd440 : inputLength[8:0];
    msg_mask = inputMsg & ~({440{1'b1}} << len_sat);
    blk      = ({72'b0, msg_r} << (10'd512 - {1'b0, len_r})) | (512'b1 << (10'd511 - {1'b0, len_r}))
             | {503'b0, len_r};
    t1       = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[t] + w[0];
    t2       = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    w_new    = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state               <= IDLE;
      computationComplete <= 1'b0;
      SHAoutput           <= '0;
      msg_r               <= '0;
      len_r               <= '0;
      w                   <= '{default: '0};
      {a, b, c, d, e, f, g, h} <= '0;
      t                   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (beginComputation) begin
          msg_r               <= msg_mask;
          len_r               <= len_sat;
          computationComplete <= 1'b0;
          state               <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < 16; i++) w[i] <= blk[511 - 32*i -: 32];
          {a, b, c, d, e, f, g, h} <= IV;
          t     <= '0;
          state <= ROUND;
        end
        ROUND: begin
          {b, c, d} <= {a, b, c};
          {f, g, h} <= {e, f, g};
          a <= t1 + t2;
          e <= d + t1;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          t     <= t + 6'd1;
          if (t == 6'd63) state <= FINAL;
        end
        FINAL: begin
          SHAoutput <= {IV[255:224] + a, IV[223:192] + b, IV[191:160] + c, IV[159:128] + d,
                        IV[127:96] + e, IV[95:64] + f, IV[63:32] + g, IV[31:0] + h};
          computationComplete <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_single_block.sv
// tb_sha256_single_block: directed and randomized checks against a whole-message SHA-256 model
module tb_sha256_single_block;
  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [439:0] inputMsg = '0;
  logic [63:0]  inputLength = '0;
  logic         beginComputation = 1'b0;
  logic         computationComplete;
  logic [255:0] SHAoutput;
  int vectors = 0;
  int miscompares = 0;
  localparam logic [255:0] DA   = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] DE   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic [31:0] iv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  sha256_single_block dut (
    .clk(clk), .n_rst(n_rst), .inputMsg(inputMsg), .inputLength(inputLength),
    .beginComputation(beginComputation), .computationComplete(computationComplete), .SHAoutput(SHAoutput)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] ref_sha(input logic [439:0] m, input logic [63:0] l);
    int n;
    logic [511:0] blk;
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] x1, x2;
    logic [255:0] r;
    n = (l > 64'd440) ? 440 : int'(l);
    blk = '0;
    for (int i = 0; i < n; i++) blk[511 - i] = m[n - 1 - i];
    blk[511 - n] = 1'b1;
    blk[63:0] = 64'(n);
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = iv[i];
    for (int i = 0; i < 64; i++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[i] + w[i];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = iv[i] + v[i];
    return r;
  endfunction
  function automatic logic [439:0] rand_msg();
    logic [439:0] r = '0;
    for (int i = 0; i < 14; i++) r = {r[407:0], 32'($urandom)};
    return r;
  endfunction
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one-edge begin pulse, then scramble the inputs to show they were sampled
  task automatic start(input logic [439:0] m, input logic [63:0] l);
    inputMsg = m;
    inputLength = l;
    beginComputation = 1'b1;
    @(posedge clk); #1;
    beginComputation = 1'b0;
    inputMsg = rand_msg();
    inputLength = {32'($urandom), 32'($urandom)};
  endtask
  task automatic wait_done(input string tag, input int elapsed, input logic [255:0] exp);
    int n = elapsed;
    while (!computationComplete && n < 230) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 256'(n), 256'(66));
    check(tag, SHAoutput, exp);
  endtask
  task automatic advance(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  initial begin
    logic [439:0] m;
    logic [63:0] l;
    advance(3);
    check("reset_complete", 256'(computationComplete), 256'(0));
    check("reset_digest", SHAoutput, '0);
    n_rst = 1'b1;
    advance(1);
    start(440'd97, 64'd8);
    wait_done("msg_a", 0, DA);
    start(440'd0, 64'd0);
    check("drop_on_restart", 256'(computationComplete), 256'(0));
    check("old_digest_held", SHAoutput, DA);
    wait_done("empty", 0, DE);
    start(440'h616263, 64'd24);
    wait_done("abc", 0, DABC);
    start({{432{1'b1}}, 8'h61}, 64'd8);
    wait_done("masking", 0, DA);
    start(440'd97, 64'd8);
    advance(10);
    start(440'h616263, 64'd24);
    wait_done("busy_ignored", 11, DA);
    start(440'h616263, 64'd24);
    check("drop_from_done", 256'(computationComplete), 256'(0));
    wait_done("abc_restart", 0, DABC);
    m = rand_msg();
    start(m, 64'hffff_ffff_0000_0001);
    wait_done("saturate", 0, ref_sha(m, 64'hffff_ffff_0000_0001));
    m = rand_msg();
    start(m, 64'd440);
    wait_done("len440", 0, ref_sha(m, 64'd440));
    m = rand_msg();
    start(m, 64'd439);
    wait_done("len439", 0, ref_sha(m, 64'd439));
    for (int i = 0; i < 6; i++) begin
      m = rand_msg();
      l = 64'($urandom_range(500));
      start(m, l);
      wait_done($sformatf("random%0d_len%0d", i, l), 0, ref_sha(m, l));
    end
    start(440'd97, 64'd8);
    advance(20);
    #3 n_rst = 1'b0;
    #1;
    check("abort_complete", 256'(computationComplete), 256'(0));
    check("abort_digest", SHAoutput, '0);
    advance(2);
    n_rst = 1'b1;
    advance(1);
    start(440'd97, 64'd8);
    wait_done("after_abort", 0, DA);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
